// File: rtl/cpu0_io_tx.sv
// cpu0 console transmitter: bus-mapped register window, byte FIFO and 8N1 serialiser.
module cpu0_io_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h0008_0000,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic        rw,
    input  logic [1:0]  m_size,
    input  logic [31:0] abus,
    input  logic [31:0] dbus_in,
    output logic [31:0] dbus_out,
    output logic        hit,
    output logic        txd,
    output logic        irq
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    // Byte lanes kept by an access of the given size.
    function automatic logic [31:0] size_mask(input logic [1:0] sz);
        logic [31:0] m;
        case (sz)
            2'b00:   m = 32'h0000_00FF;
            2'b01:   m = 32'h0000_FFFF;
            2'b10:   m = 32'h00FF_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

    // Lanes a TXDATA write pushes: a byte store always pushes; wider stores skip
    // NUL bytes and push nothing at all when the first byte is NUL.
    function automatic logic [3:0] push_lanes(input logic [1:0] sz, input logic [31:0] w);
        logic [3:0] m;
        m = 4'b0000;
        if (sz == 2'b00) begin
            m = 4'b0001;
        end else if (w[7:0] != 8'h00) begin
            for (int i = 0; i < 4; i++) begin
                m[i] = (2'(i) <= sz) && (w[8*i +: 8] != 8'h00);
            end
        end
        return m;
    endfunction

    // Registers
    logic             en_d_q,     en_d_d;
    logic [15:0]      div_q,      div_d;
    logic             ie_q,       ie_d;
    logic             ovf_q,      ovf_d;
    logic [3:0]       seq_mask_q, seq_mask_d;
    logic [31:0]      seq_word_q, seq_word_d;
    logic [7:0]       fifo_mem_q [FIFO_DEPTH];
    logic [7:0]       fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0] count_q,    count_d;
    state_e           state_q,    state_d;
    logic [15:0]      tmr_q,      tmr_d;
    logic [2:0]       bit_idx_q,  bit_idx_d;
    logic [7:0]       shreg_q,    shreg_d;
    logic             txd_q,      txd_d;
    logic             irq_q,      irq_d;

    // Combinational helpers
    logic [31:0] offset_c;
    logic [1:0]  reg_sel_c;
    logic        accept_c;
    logic [31:0] wmask_c;
    logic [31:0] rd_word_c;
    logic        empty_c;
    logic        full_c;
    logic        busy_c;
    logic        push_c;
    logic        push_do_c;
    logic [7:0]  push_byte_c;
    logic        pop_c;
    logic [15:0] div_m1_c;

    // Address decode and one-shot accept on the rising edge of en.
    assign offset_c  = abus - BASE_ADDR;
    assign hit       = en && (offset_c < 32'd12);
    assign reg_sel_c = offset_c[3:2];
    assign accept_c  = hit && !en_d_q;
    assign wmask_c   = size_mask(m_size);

    assign empty_c  = (count_q == '0);
    assign full_c   = (count_q == CNT_W'(FIFO_DEPTH));
    assign busy_c   = (seq_mask_q != 4'b0000) || (state_q != S_IDLE);
    assign div_m1_c = (div_q == 16'd0) ? 16'd0 : (div_q - 16'd1);

    // Read data mux, zero-extended by the access size.
    always_comb begin
        rd_word_c = 32'h0;
        case (reg_sel_c)
            REG_STATUS: rd_word_c = {19'b0, 5'(count_q), 4'b0, ovf_q, busy_c, full_c, empty_c};
            REG_CTRL:   rd_word_c = {15'b0, ie_q, div_q};
            default:    rd_word_c = 32'h0;
        endcase
    end

    assign dbus_out = (hit && rw) ? (rd_word_c & wmask_c) : 32'hZZZZ_ZZZZ;

    // Register writes, push sequencer and overflow tracking.
    always_comb begin
        en_d_d      = en;
        div_d       = div_q;
        ie_d        = ie_q;
        ovf_d       = ovf_q;
        seq_mask_d  = seq_mask_q;
        seq_word_d  = seq_word_q;
        push_c      = 1'b0;
        push_byte_c = 8'h00;

        // Push the lowest pending lane each cycle.
        if (seq_mask_q[0]) begin
            push_c        = 1'b1;
            push_byte_c   = seq_word_q[7:0];
            seq_mask_d[0] = 1'b0;
        end else if (seq_mask_q[1]) begin
            push_c        = 1'b1;
            push_byte_c   = seq_word_q[15:8];
            seq_mask_d[1] = 1'b0;
        end else if (seq_mask_q[2]) begin
            push_c        = 1'b1;
            push_byte_c   = seq_word_q[23:16];
            seq_mask_d[2] = 1'b0;
        end else if (seq_mask_q[3]) begin
            push_c        = 1'b1;
            push_byte_c   = seq_word_q[31:24];
            seq_mask_d[3] = 1'b0;
        end

        if (accept_c) begin
            case (reg_sel_c)
                REG_TXDATA: begin
                    if (!rw) begin
                        if (seq_mask_q != 4'b0000) begin
                            ovf_d = 1'b1;
                        end else begin
                            seq_word_d = dbus_in;
                            seq_mask_d = push_lanes(m_size, dbus_in);
                        end
                    end
                end
                REG_STATUS: begin
                    if (rw) begin
                        ovf_d = 1'b0;
                    end
                end
                REG_CTRL: begin
                    if (!rw) begin
                        div_d = dbus_in[15:0] & wmask_c[15:0];
                        ie_d  = dbus_in[16] & wmask_c[16];
                    end
                end
                default: ;
            endcase
        end

        // A dropped push outranks a same-cycle STATUS clear.
        if (push_c && full_c && !pop_c) begin
            ovf_d = 1'b1;
        end
    end

    assign push_do_c = push_c && (!full_c || pop_c);

    // FIFO pointers, occupancy and storage.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        fifo_mem_d = fifo_mem_q;
        if (push_do_c) begin
            fifo_mem_d[wr_ptr_q] = push_byte_c;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_do_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Serialiser next state; txd follows the state one clock later.
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        pop_c     = 1'b0;
        txd_d     = 1'b1;
        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (!empty_c) begin
                    pop_c   = 1'b1;
                    shreg_d = fifo_mem_q[rd_ptr_q];
                    tmr_d   = div_m1_c;
                    state_d = S_START;
                end
            end
            S_START: begin
                txd_d = 1'b0;
                if (tmr_q == 16'd0) begin
                    tmr_d     = div_m1_c;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end
            S_DATA: begin
                txd_d = shreg_q[0];
                if (tmr_q == 16'd0) begin
                    tmr_d   = div_m1_c;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end
            S_STOP: begin
                txd_d = 1'b1;
                if (tmr_q == 16'd0) begin
                    tmr_d = div_m1_c;
                    if (!empty_c) begin
                        pop_c   = 1'b1;
                        shreg_d = fifo_mem_q[rd_ptr_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Interrupt computed from next-state values so it is registered without lag.
    assign irq_d = ie_d && (count_d == '0) && (state_d == S_IDLE);

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            en_d_q     <= 1'b0;
            div_q      <= DIV_RESET;
            ie_q       <= 1'b0;
            ovf_q      <= 1'b0;
            seq_mask_q <= 4'b0000;
            seq_word_q <= 32'h0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            tmr_q      <= 16'd0;
            bit_idx_q  <= 3'd0;
            shreg_q    <= 8'h00;
            txd_q      <= 1'b1;
            irq_q      <= 1'b0;
        end else begin
            en_d_q     <= en_d_d;
            div_q      <= div_d;
            ie_q       <= ie_d;
            ovf_q      <= ovf_d;
            seq_mask_q <= seq_mask_d;
            seq_word_q <= seq_word_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            txd_q      <= txd_d;
            irq_q      <= irq_d;
        end
    end

    // FIFO storage; contents are meaningless while count is zero, so no reset.
    always_ff @(posedge clock) begin
        fifo_mem_q <= fifo_mem_d;
    end

    assign txd = txd_q;
    assign irq = irq_q;

endmodule

// File: tb/tb_cpu0_io_tx.sv
// Self-checking bench for cpu0_io_tx: bus driver, UART line monitor, byte-queue reference.
module tb_cpu0_io_tx;

    localparam logic [31:0] BASE = 32'h0008_0000;
    localparam logic [1:0]  SZ_B = 2'b00;
    localparam logic [1:0]  SZ_H = 2'b01;
    localparam logic [1:0]  SZ_W = 2'b11;

    logic        clock = 1'b0;
    logic        reset;
    logic        en;
    logic        rw;
    logic [1:0]  m_size;
    logic [31:0] abus;
    logic [31:0] dbus_in;
    wire  [31:0] dbus_out;
    logic        hit;
    logic        txd;
    logic        irq;

    cpu0_io_tx dut (
        .clock    (clock),
        .reset    (reset),
        .en       (en),
        .rw       (rw),
        .m_size   (m_size),
        .abus     (abus),
        .dbus_in  (dbus_in),
        .dbus_out (dbus_out),
        .hit      (hit),
        .txd      (txd),
        .irq      (irq)
    );

    always #5 clock = ~clock;

    int unsigned  n_cmp = 0;
    int unsigned  n_bad = 0;
    longint       cyc = 0;
    bit           mon_en = 1'b0;
    int           mon_div = 16;
    byte unsigned exp_q[$];
    byte unsigned rx_q[$];
    longint       start_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: bytes a TXDATA store should put on the line.
    task automatic model_tx(input logic [1:0] sz, input logic [31:0] w);
        byte unsigned bs[4];
        for (int i = 0; i < 4; i++) bs[i] = w[8*i +: 8];
        if (sz == SZ_B) begin
            exp_q.push_back(bs[0]);
        end else if (bs[0] != 0) begin
            for (int i = 0; i <= int'(sz); i++)
                if (bs[i] != 0) exp_q.push_back(bs[i]);
        end
    endtask

    function automatic logic [31:0] status_exp(input int cnt, input bit ovf, input bit busy);
        return {19'b0, 5'(cnt), 4'b0, ovf, busy, (cnt == 16), (cnt == 0)};
    endfunction

    task automatic bus_op(input logic r, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] wd, input int hold,
                          output logic [31:0] rdat, output logic hseen);
        @(posedge clock);
        #1;
        en = 1'b1; rw = r; m_size = sz; abus = addr; dbus_in = wd;
        @(negedge clock);
        rdat  = dbus_out;
        hseen = hit;
        repeat (hold) @(posedge clock);
        #1;
        en = 1'b0;
    endtask

    task automatic wr(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] r;
        logic h;
        bus_op(1'b0, sz, addr, wd, 1, r, h);
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] exp);
        logic [31:0] r;
        logic h;
        bus_op(1'b1, sz, addr, 32'h0, 1, r, h);
        check_eq(tag, r, exp);
    endtask

    task automatic hit_chk(input string tag, input logic [31:0] addr, input logic exp);
        logic [31:0] r;
        logic h;
        bus_op(1'b1, SZ_W, addr, 32'h0, 1, r, h);
        check_eq(tag, 32'(h), 32'(exp));
    endtask

    task automatic txw(input logic [1:0] sz, input logic [31:0] wd);
        wr(sz, BASE, wd);
        model_tx(sz, wd);
    endtask

    task automatic set_div(input logic [31:0] ctrl);
        wr(SZ_W, BASE + 32'd8, ctrl);
        mon_div = (ctrl[15:0] == 16'd0) ? 1 : int'(ctrl[15:0]);
    endtask

    task automatic wait_start(input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clock);
            if (txd == 1'b0) found = 1'b1;
        end
        check_eq(tag, 32'(found), 32'h1);
    endtask

    // Wait (bounded) for all expected bytes, then compare the received stream.
    task automatic drain_cmp(input string tag);
        int budget = (exp_q.size() + 1) * 10 * mon_div + 50;
        int t = 0;
        int n;
        while (rx_q.size() < exp_q.size() && t < budget) begin
            @(posedge clock);
            t++;
        end
        repeat (10 * mon_div + 20) @(posedge clock);
        check_eq({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check_eq({tag, "_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
        rx_q.delete();
        exp_q.delete();
    endtask

    // Line monitor: mid-bit sampling of 8N1 frames at the programmed divider.
    initial begin : monitor
        logic       prev;
        logic [7:0] b;
        longint     t0;
        prev = 1'b1;
        forever begin
            @(negedge clock);
            if (mon_en && prev && !txd) begin
                t0 = cyc;
                repeat (mon_div / 2) @(negedge clock);
                check_eq("mon_start_bit", 32'(txd), 32'h0);
                for (int i = 0; i < 8; i++) begin
                    repeat (mon_div) @(negedge clock);
                    b[i] = txd;
                end
                repeat (mon_div) @(negedge clock);
                check_eq("mon_stop_bit", 32'(txd), 32'h1);
                if (mon_en) begin
                    rx_q.push_back(b);
                    start_q.push_back(t0);
                end
                prev = txd;
            end else begin
                prev = txd;
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [9:0]  fb;
        logic [31:0] r;
        logic        h;
        logic [31:0] w;
        logic [1:0]  sz;
        int          errs;
        int          lows;

        reset = 1'b1; en = 1'b0; rw = 1'b0; m_size = SZ_B; abus = 32'h0; dbus_in = 32'h0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("rst_txd", 32'(txd), 32'h1);
        check_eq("rst_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        mon_en = 1'b1;
        mon_div = 16;

        // Reset values of the register window
        rd_chk("t1_status_lb", SZ_B, BASE + 32'd4, 32'h1);
        rd_chk("t1_status_ld", SZ_W, BASE + 32'd4, 32'h1);
        rd_chk("t1_ctrl_ld",   SZ_W, BASE + 32'd8, 32'h10);
        rd_chk("t1_txdata_ld", SZ_W, BASE,         32'h0);
        rd_chk("t1_ctrl_lb11", SZ_B, BASE + 32'd11, 32'h10);

        // Exact frame waveform at DIV=4
        set_div(32'h4);
        rd_chk("t2_ctrl", SZ_W, BASE + 32'd8, 32'h4);
        txw(SZ_B, 32'h41);
        wait_start("t2_start_seen");
        fb = {1'b1, 8'h41, 1'b0};
        errs = 0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clock);
            if (txd !== fb[k / 4]) errs++;
        end
        check_eq("t2_wave_errs", 32'(errs), 32'h0);
        @(negedge clock);
        check_eq("t2_idle_after", 32'(txd), 32'h1);
        check_eq("t2_irq_off", 32'(irq), 32'h0);
        rd_chk("t2_status", SZ_W, BASE + 32'd4, 32'h1);
        drain_cmp("t2_rx");

        // Interrupt follows IE, empty FIFO and idle line
        set_div(32'h0001_0004);
        repeat (2) @(negedge clock);
        check_eq("t2_irq_idle", 32'(irq), 32'h1);
        txw(SZ_B, 32'h5A);
        wait_start("t2_irq_start");
        check_eq("t2_irq_busy", 32'(irq), 32'h0);
        drain_cmp("t2_irq_rx");
        @(negedge clock);
        check_eq("t2_irq_back", 32'(irq), 32'h1);
        set_div(32'h4);
        repeat (2) @(negedge clock);
        check_eq("t2_irq_ie0", 32'(irq), 32'h0);

        // Console semantics and back-to-back frames
        start_q.delete();
        txw(SZ_W, 32'h0043_4241);
        drain_cmp("t3_abc");
        check_eq("t3_frames", 32'(start_q.size()), 32'h3);
        if (start_q.size() >= 3) begin
            check_eq("t3_gap1", 32'(start_q[1] - start_q[0]), 32'd40);
            check_eq("t3_gap2", 32'(start_q[2] - start_q[1]), 32'd40);
        end
        txw(SZ_W, 32'h0000_0042);
        drain_cmp("t3_b");
        txw(SZ_W, 32'h4100_0000);
        drain_cmp("t3_none");
        txw(SZ_H, 32'h0000_4241);
        drain_cmp("t3_sh");

        // Store while the sequencer is still pushing is dropped and flags OVF
        txw(SZ_W, 32'h4443_4241);
        wr(SZ_B, BASE, 32'h5A);
        drain_cmp("t_drop");
        rd_chk("drop_status_ovf", SZ_W, BASE + 32'd4, status_exp(0, 1'b1, 1'b0));
        rd_chk("drop_status_clr", SZ_W, BASE + 32'd4, status_exp(0, 1'b0, 1'b0));

        // Randomized stores at random dividers
        for (int g = 0; g < 4; g++) begin
            set_div(32'($urandom_range(1, 3)));
            for (int j = 0; j < 3; j++) begin
                sz = 2'($urandom_range(0, 3));
                for (int k = 0; k < 4; k++)
                    w[8*k +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                txw(sz, w);
                repeat (4 + $urandom_range(0, 3)) @(posedge clock);
            end
            drain_cmp("rnd");
            rd_chk("rnd_status", SZ_W, BASE + 32'd4, 32'h1);
        end

        // Window boundaries, side-effect-free accesses, en held high
        set_div(32'h4);
        hit_chk("t6_hit_base12", BASE + 32'd12, 1'b0);
        hit_chk("t6_hit_zero",   32'h0,         1'b0);
        hit_chk("t6_hit_below",  BASE - 32'd1,  1'b0);
        hit_chk("t6_hit_base11", BASE + 32'd11, 1'b1);
        hit_chk("t6_hit_base",   BASE,          1'b1);
        wr(SZ_W, BASE + 32'd12, 32'h41);
        wr(SZ_B, 32'h0, 32'h41);
        wr(SZ_B, BASE + 32'd4, 32'h41);
        bus_op(1'b0, SZ_B, BASE, 32'h5A, 5, r, h);
        model_tx(SZ_B, 32'h5A);
        drain_cmp("t6_rx");
        rd_chk("t6_status", SZ_W, BASE + 32'd4, 32'h1);
        rd_chk("t6_ctrl",   SZ_W, BASE + 32'd8, 32'h4);

        // FIFO fill and overflow at a slow divider: the first byte is taken by the
        // serialiser at once, the next 16 fill the FIFO and the 18th is dropped.
        mon_en = 1'b0;
        set_div(32'd1000);
        for (int i = 0; i < 18; i++) begin
            wr(SZ_B, BASE, 32'h30 + 32'(i));
            @(posedge clock);
        end
        rd_chk("t4_status_ovf", SZ_W, BASE + 32'd4, status_exp(16, 1'b1, 1'b1));
        rd_chk("t4_status_clr", SZ_W, BASE + 32'd4, status_exp(16, 1'b0, 1'b1));
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_eq("t4_rst_txd", 32'(txd), 32'h1);
        rd_chk("t4_rst_status", SZ_W, BASE + 32'd4, 32'h1);
        rd_chk("t4_rst_ctrl",   SZ_W, BASE + 32'd8, 32'h10);

        // Reset during data bit 3 of a frame
        set_div(32'h4);
        wr(SZ_B, BASE, 32'h55);
        repeat (2) @(posedge clock);
        wr(SZ_B, BASE, 32'h66);
        wait_start("t5_start_seen");
        repeat (17) @(negedge clock);
        check_eq("t5_bit3_low", 32'(txd), 32'h0);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_eq("t5_txd_after_rst", 32'(txd), 32'h1);
        reset = 1'b0;
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (txd !== 1'b1) lows++;
        end
        check_eq("t5_no_frames", 32'(lows), 32'h0);
        rd_chk("t5_status", SZ_W, BASE + 32'd4, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
